// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, state enum and sizing for muldiv_unit
package muldiv_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_AW    = 4;
  localparam int ITER      = DEF_WIDTH;

  localparam logic [1:0] OP_MULLO = 2'b00;
  localparam logic [1:0] OP_MULHI = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative unsigned multiply/divide unit with register file write-back
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    dst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             wen,
  output logic [AW-1:0]    waddr,
  output logic [WIDTH-1:0] wdata
);

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  logic [1:0]         op_q;
  logic [AW-1:0]      dst_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   res;

  // acc holds {hi, lo}: for MUL hi is the running sum and lo the remaining multiplier;
  // for DIV hi is the partial remainder and lo the dividend shifting into the quotient.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    shifted = acc[2*WIDTH-1:WIDTH-1];
    acc_nxt = acc;
    if (op_q[1]) begin
      if (shifted >= {1'b0, opnd_q})
        acc_nxt = {shifted[WIDTH-1:0] - opnd_q, acc[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0])
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // MULHI and REMU live in the upper half, MULLO and DIVU in the lower half.
  assign res = op_q[0] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      wen    <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
      op_q   <= '0;
      dst_q  <= '0;
      opnd_q <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done  <= 1'b0;
          wen   <= 1'b0;
          waddr <= '0;
          wdata <= '0;
          if (start) begin
            op_q   <= op;
            dst_q  <= dst;
            opnd_q <= op[1] ? b : a;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
            cnt    <= CW'(ITER - 1);
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          if (cnt == '0) begin
            done  <= 1'b1;
            wen   <= (dst_q != '0);
            waddr <= dst_q;
            wdata <= res;
            state <= S_WB;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WB: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          wen   <= 1'b0;
          waddr <= '0;
          wdata <= '0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          wen   <= 1'b0;
          waddr <= '0;
          wdata <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  dst;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        wen;
  logic [3:0]  waddr;
  logic [15:0] wdata;

  int total;
  int bad;

  int          ob_done_cyc;
  int          ob_done_cnt;
  int          ob_wen_cnt;
  int          ob_busy_cnt;
  int          ob_leak;
  logic [15:0] ob_wdata;
  logic [3:0]  ob_waddr;
  logic        busy_v [0:24];

  muldiv_unit #(.WIDTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dst(dst), .a(a), .b(b),
    .busy(busy), .done(done), .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = 32'(x) * 32'(y);
    case (o)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (y == 0) ? 16'hFFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Issues one op at edge T0 and records what the DUT shows in cycles T0+1..T0+24.
  task automatic do_op(input logic [1:0] o, input logic [3:0] d, input logic [15:0] x,
                       input logic [15:0] y, input int start_at, input int rst_at);
    ob_done_cyc = -1; ob_done_cnt = 0; ob_wen_cnt = 0; ob_busy_cnt = 0; ob_leak = 0;
    ob_wdata = 16'h0; ob_waddr = 4'h0;
    @(negedge clk);
    start = 1'b1; op = o; dst = d; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); dst = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      busy_v[k] = busy;
      if (busy) ob_busy_cnt++;
      if (done) begin
        ob_done_cnt++;
        if (ob_done_cyc < 0) begin
          ob_done_cyc = k;
          ob_wdata = wdata;
          ob_waddr = waddr;
        end
      end
      if (wen) ob_wen_cnt++;
      if (!done && (wen || wdata != 16'h0)) ob_leak++;
      start = (k == start_at);
      rst   = (k == rst_at);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; op = 2'b00; dst = 4'd5; a = 16'd9; b = 16'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (wen !== 1'b0)    begin bad++; $display("FAIL reset_wen got=%b exp=0", wen); end
    total++; if (waddr !== 4'h0)  begin bad++; $display("FAIL reset_waddr got=%h exp=0", waddr); end
    total++; if (wdata !== 16'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_directed;
    logic [1:0]  ops [8];
    logic [15:0] xs  [8];
    logic [15:0] ys  [8];
    logic [15:0] exp_d;
    ops = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
    xs  = '{16'd300, 16'd300, 16'hFFFF, 16'hFFFF, 16'd1000, 16'd1000, 16'h1234, 16'h1234};
    ys  = '{16'd500, 16'd500, 16'hFFFF, 16'hFFFF, 16'd7, 16'd7, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      do_op(ops[i], 4'd3, xs[i], ys[i], -1, -1);
      exp_d = model(ops[i], xs[i], ys[i]);
      total++; if (ob_wdata !== exp_d) begin bad++; $display("FAIL dir_wdata[%0d] got=%h exp=%h", i, ob_wdata, exp_d); end
      total++; if (ob_done_cyc != 17) begin bad++; $display("FAIL dir_latency[%0d] got=%0d exp=17", i, ob_done_cyc); end
      total++; if (ob_waddr !== 4'd3) begin bad++; $display("FAIL dir_waddr[%0d] got=%h exp=3", i, ob_waddr); end
      total++; if (ob_wen_cnt != 1) begin bad++; $display("FAIL dir_wen[%0d] got=%0d exp=1", i, ob_wen_cnt); end
      total++; if (ob_done_cnt != 1) begin bad++; $display("FAIL dir_done[%0d] got=%0d exp=1", i, ob_done_cnt); end
      total++; if (ob_busy_cnt != 17 || busy_v[1] !== 1'b1 || busy_v[18] !== 1'b0)
        begin bad++; $display("FAIL dir_busy[%0d] got=%0d exp=17", i, ob_busy_cnt); end
      total++; if (ob_leak != 0) begin bad++; $display("FAIL dir_leak[%0d] got=%0d exp=0", i, ob_leak); end
    end
  endtask

  task automatic test_dst_zero;
    do_op(2'($urandom), 4'd0, 16'($urandom), 16'($urandom), -1, -1);
    total++; if (ob_done_cnt != 1 || ob_done_cyc != 17)
      begin bad++; $display("FAIL dst0_done got=%0d@%0d exp=1@17", ob_done_cnt, ob_done_cyc); end
    total++; if (ob_wen_cnt != 0) begin bad++; $display("FAIL dst0_wen got=%0d exp=0", ob_wen_cnt); end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [3:0]  d;
    logic [15:0] x, y, exp_d;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom);
      d = 4'($urandom_range(1, 15));
      x = 16'($urandom);
      y = (i % 6 == 5) ? 16'h0 : ((i % 3 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom));
      do_op(o, d, x, y, -1, -1);
      exp_d = model(o, x, y);
      total++; if (ob_wdata !== exp_d || ob_waddr !== d || ob_done_cyc != 17 || ob_wen_cnt != 1)
        begin bad++; $display("FAIL rand[%0d] op=%0d a=%h b=%h got=%h@%0d addr=%h exp=%h@17 addr=%h",
                              i, o, x, y, ob_wdata, ob_done_cyc, ob_waddr, exp_d, d); end
    end
  endtask

  task automatic test_start_while_busy;
    logic [15:0] exp_d;
    exp_d = model(2'b10, 16'd50000, 16'd123);
    do_op(2'b10, 4'd9, 16'd50000, 16'd123, 5, -1);
    total++; if (ob_done_cnt != 1 || ob_done_cyc != 17)
      begin bad++; $display("FAIL busy_start_done got=%0d@%0d exp=1@17", ob_done_cnt, ob_done_cyc); end
    total++; if (ob_wdata !== exp_d) begin bad++; $display("FAIL busy_start_wdata got=%h exp=%h", ob_wdata, exp_d); end
  endtask

  task automatic test_reset_abort;
    logic [15:0] exp_d;
    do_op(2'b00, 4'd7, 16'd1234, 16'd4321, -1, 8);
    total++; if (busy_v[9] !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_v[9]); end
    total++; if (ob_done_cnt != 0 || ob_wen_cnt != 0)
      begin bad++; $display("FAIL abort_wb got=done%0d/wen%0d exp=0/0", ob_done_cnt, ob_wen_cnt); end
    exp_d = model(2'b11, 16'd40000, 16'd333);
    do_op(2'b11, 4'd12, 16'd40000, 16'd333, -1, -1);
    total++; if (ob_wdata !== exp_d || ob_done_cyc != 17 || ob_waddr !== 4'd12)
      begin bad++; $display("FAIL after_abort got=%h@%0d exp=%h@17", ob_wdata, ob_done_cyc, exp_d); end
  endtask

  task automatic test_back_to_back;
    int          cyc [$];
    logic [15:0] vals [$];
    logic [15:0] exp_d;
    exp_d = model(2'b01, 16'hBEEF, 16'h1357);
    @(negedge clk);
    start = 1'b1; op = 2'b01; dst = 4'd2; a = 16'hBEEF; b = 16'h1357;
    @(posedge clk);
    for (int k = 1; k <= 56; k++) begin
      @(negedge clk);
      if (done) begin
        cyc.push_back(k);
        vals.push_back(wdata);
      end
    end
    start = 1'b0;
    total++; if (cyc.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", cyc.size()); end
    for (int i = 0; i < cyc.size() && i < 3; i++) begin
      total++; if (cyc[i] != 17 + 18 * i || vals[i] !== exp_d)
        begin bad++; $display("FAIL b2b[%0d] got=%h@%0d exp=%h@%0d", i, vals[i], cyc[i], exp_d, 17 + 18 * i); end
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; dst = 4'd0; a = 16'h0; b = 16'h0;
    test_reset;
    test_directed;
    test_dst_zero;
    test_random;
    test_start_while_busy;
    test_reset_abort;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
